pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Central pipeline stall controller for the five-stage MIPS core. Collects stall requests from ID (load-use, branch) and EX (multi-cycle divide), and sequences them through a small state machine. Drives the shared `stall` bus that the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers obey. Also provides busy/timeout status and a saturating stall-cycle counter for performance debug.

## Interface
- `STALL_W`, 6: stall bus width (`StallBus`); bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; `Stop`=1, `NoStop`=0.
- `LOAD_BUBBLES`, 1: stalled cycles per load-use event; must be ≥1.
- `DIV_CYCLES`, 33: divide timeout, counted in stalled cycles; must be ≥2.
- `clk  in  1`: core clock. One clock; all state updates on its rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `stallreq_for_load  in  1`: from ID; the instruction in ID consumes a load result still in EX.
- `stallreq_for_bru  in  1`: from ID; the branch operand is not yet resolvable.
- `stallreq_for_ex  in  1`: from EX; a one-cycle pulse when a divide starts.
- `div_ready  in  1`: from EX; the divide result is valid this cycle.
- `stall  out  STALL_W`: stall bus.
- `busy  out  1`: state ≠ RUN.
- `div_timeout  out  1`: sticky; the divider failed to respond within `DIV_CYCLES`.
- `stall_cnt  out  32`: number of cycles with `stall`≠0; saturates.

## Operation
- States:
  - RUN, LOAD, DIV. The state and 2-bit encoding are registered.
  - `cnt` is a 6-bit down-counter.
  - `ld_block` is a 1-bit mask.
- `stall` is combinational from the state and inputs. It is forced to 0 while `rst`=1.
- Stall codes:
  - BRU = 6'b000011: freeze PC and IF; bubble into ID.
  - LOAD = 6'b000111: freeze through ID; bubble into EX.
  - DIV = 6'b001111: freeze through EX; bubble into MEM.
- RUN, priority is `stallreq_for_ex` > (`stallreq_for_load` & ~`ld_block`) > `stallreq_for_bru`:
  - ex request:
    - `stall`=DIV this cycle.
    - Next state DIV, `cnt`←`DIV_CYCLES`-1.
  - load request:
    - `stall`=LOAD this cycle.
    - If `LOAD_BUBBLES`=1: stay in RUN and set `ld_block`←1.
    - Otherwise: go to LOAD with `cnt`←`LOAD_BUBBLES`-1.
  - bru request: `stall`=BRU this cycle only; no state change.
  - No request: `stall`=0.
  - `ld_block` is cleared after every RUN cycle in which it was not just set. It therefore masks the load request for exactly one RUN cycle after a load stall, which guarantees forward progress.
- LOAD:
  - `stall`=LOAD.
  - If `cnt`=1: go to RUN and set `ld_block`←1. Otherwise decrement `cnt`.
  - All inputs are ignored in this state.
- DIV:
  - If `div_ready`=1: `stall`=0, go to RUN.
  - Else if `cnt`=0: `stall`=0, go to RUN, `div_timeout`←1.
  - Otherwise: `stall`=DIV and decrement `cnt`.
  - `stallreq_for_load`, `stallreq_for_bru` and `stallreq_for_ex` are ignored in this state.
- `div_ready` is ignored outside DIV.
- `stall_cnt` increments in every cycle where `stall`≠0. It holds at 32'hFFFF_FFFF.
- Reset, including mid-operation, takes effect immediately:
  - state←RUN, `cnt`←0, `ld_block`←0.
  - `div_timeout`←0, `stall_cnt`←0.
  - Outputs: `stall`=0, `busy`=0.

## Timing
- A request is visible on `stall` in the same cycle (zero latency). The pipeline registers sample `stall` at the next edge.
- Load-use event: exactly `LOAD_BUBBLES` consecutive LOAD cycles, counting the request cycle.
- Divide:
  - With `div_ready` in DIV cycle k (k≥1 after the request cycle), there are 1+(k-1) stalled cycles and `stall`=0 in cycle k.
  - With no `div_ready`: exactly `DIV_CYCLES` stalled cycles, then one unstalled cycle in which `div_timeout` rises (registered, visible the following cycle).
- `busy` is registered: 1 from the cycle after entry into LOAD/DIV until the cycle after the return to RUN.
- Simultaneous load and bru requests: LOAD wins. The bru request is re-evaluated in the next RUN cycle because ID is frozen.
- An ex request coinciding with `ld_block`=1 is still accepted.

## Test plan
- Reset then idle, all inputs 0 → `stall`=0, `busy`=0, `stall_cnt`=0 for 10 cycles.
- `LOAD_BUBBLES`=2, hold `stallreq_for_load`=1 for 5 cycles → `stall`=000111 for 2 cycles, then 0 for 1 cycle (`ld_block`), then 000111 for 2 cycles; `stall_cnt`=4.
- `stallreq_for_ex` pulse, `div_ready` raised on the 5th cycle after the request → `stall`=001111 for 5 cycles then 0; `div_timeout`=0; `stall_cnt`=5.
- `DIV_CYCLES`=33, ex pulse, `div_ready` never asserted → 33 stalled cycles, return to RUN, `div_timeout`=1 and stays 1 until `rst`.
- Same-cycle `stallreq_for_ex`=1, `stallreq_for_load`=1, `stallreq_for_bru`=1 → `stall`=001111; the load and bru requests are ignored for the whole DIV period.
- Assert `rst` in the 3rd DIV cycle → `stall`=0 and `busy`=0 immediately; after release, a `stallreq_for_bru` pulse gives `stall`=000011 for exactly 1 cycle.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl_if
// Purpose  : Bundle of stall requests from ID/EX and the stall bus and
//            status returned by the central stall controller.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_stall_ctrl_if #(
    parameter int STALL_W = 6
);
    logic               stallreq_for_load;
    logic               stallreq_for_bru;
    logic               stallreq_for_ex;
    logic               div_ready;
    logic [STALL_W-1:0] stall;
    logic               busy;
    logic               div_timeout;
    logic [31:0]        stall_cnt;

    // Pipeline side: raises requests, obeys the stall bus
    modport master (
        output stallreq_for_load, stallreq_for_bru, stallreq_for_ex, div_ready,
        input  stall, busy, div_timeout, stall_cnt
    );

    // Controller side
    modport slave (
        input  stallreq_for_load, stallreq_for_bru, stallreq_for_ex, div_ready,
        output stall, busy, div_timeout, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Purpose  : Central stall controller for the five-stage core. Arbitrates
//            load-use, branch and divide stall requests, drives the shared
//            stall bus and keeps busy/timeout/stall-cycle status.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int STALL_W      = 6,
    parameter int LOAD_BUBBLES = 1,
    parameter int DIV_CYCLES   = 33
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pipe_stall_ctrl_if.slave bus
);

    localparam logic [1:0] c_ST_RUN  = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;

    localparam logic [STALL_W-1:0] c_STALL_NONE = '0;
    localparam logic [STALL_W-1:0] c_STALL_BRU  = STALL_W'(6'b000011);
    localparam logic [STALL_W-1:0] c_STALL_LOAD = STALL_W'(6'b000111);
    localparam logic [STALL_W-1:0] c_STALL_DIV  = STALL_W'(6'b001111);

    localparam logic [5:0] c_LOAD_INIT = 6'(LOAD_BUBBLES - 1);
    localparam logic [5:0] c_DIV_INIT  = 6'(DIV_CYCLES - 1);

    logic [1:0]         r_state;
    logic [5:0]         r_cnt;
    logic               r_ld_block;
    logic               r_busy;
    logic               r_div_timeout;
    logic [31:0]        r_stall_cnt;

    logic [STALL_W-1:0] w_stall;
    logic [1:0]         w_state_nxt;
    logic [5:0]         w_cnt_nxt;
    logic               w_ld_block_nxt;
    logic               w_timeout_set;

    // Zero-latency stall decode and next-state selection
    always_comb begin
        w_stall        = c_STALL_NONE;
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ld_block_nxt = r_ld_block;
        w_timeout_set  = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                // The load mask lives for a single RUN cycle unless re-armed below
                w_ld_block_nxt = 1'b0;
                if (bus.stallreq_for_ex) begin
                    w_stall     = c_STALL_DIV;
                    w_state_nxt = c_ST_DIV;
                    w_cnt_nxt   = c_DIV_INIT;
                end else if (bus.stallreq_for_load && !r_ld_block) begin
                    w_stall = c_STALL_LOAD;
                    if (LOAD_BUBBLES == 1) begin
                        w_ld_block_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_LOAD;
                        w_cnt_nxt   = c_LOAD_INIT;
                    end
                end else if (bus.stallreq_for_bru) begin
                    w_stall = c_STALL_BRU;
                end
            end
            c_ST_LOAD: begin
                w_stall = c_STALL_LOAD;
                if (r_cnt == 6'd1) begin
                    w_state_nxt    = c_ST_RUN;
                    w_ld_block_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            c_ST_DIV: begin
                if (bus.div_ready) begin
                    w_state_nxt = c_ST_RUN;
                end else if (r_cnt == 6'd0) begin
                    w_state_nxt   = c_ST_RUN;
                    w_timeout_set = 1'b1;
                end else begin
                    w_stall   = c_STALL_DIV;
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
                w_cnt_nxt   = 6'd0;
            end
        endcase
        // The pipeline must never see a stall while reset is held
        if (rst) begin
            w_stall = c_STALL_NONE;
        end
    end

    // State, counters and registered status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_RUN;
            r_cnt         <= 6'd0;
            r_ld_block    <= 1'b0;
            r_busy        <= 1'b0;
            r_div_timeout <= 1'b0;
            r_stall_cnt   <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ld_block <= w_ld_block_nxt;
            r_busy     <= (w_state_nxt != c_ST_RUN);
            if (w_timeout_set) begin
                r_div_timeout <= 1'b1;
            end
            if ((w_stall != c_STALL_NONE) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign bus.stall       = w_stall;
    assign bus.busy        = r_busy;
    assign bus.div_timeout = r_div_timeout;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Purpose  : Self-checking bench for pipe_stall_ctrl with an event-level
//            reference model and directed scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int c_LB  = 2;
    localparam int c_DIV = 33;
    localparam logic [5:0] c_S_BRU  = 6'h03;
    localparam logic [5:0] c_S_LOAD = 6'h07;
    localparam logic [5:0] c_S_DIV  = 6'h0F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.STALL_W(6)) bus ();

    pipe_stall_ctrl #(
        .STALL_W      (6),
        .LOAD_BUBBLES (c_LB),
        .DIV_CYCLES   (c_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: current stall event and how many cycles it has run
    int          ev   = 0;   // 0 idle, 1 load event, 2 divide event
    int          age  = 0;
    int          mask = 0;
    logic        m_busy = 1'b0;
    logic        m_to   = 1'b0;
    logic [31:0] m_cnt  = 32'd0;
    logic        rec    = 1'b0;
    logic [5:0]  seq_q[$];

    always @(negedge clk) begin : compare
        logic [5:0] exp_stall;
        if (rst) begin
            check("rst_stall", 32'(bus.stall), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_timeout", 32'(bus.div_timeout), 32'd0);
            check("rst_stall_cnt", bus.stall_cnt, 32'd0);
            ev = 0; age = 0; mask = 0;
            m_busy = 1'b0; m_to = 1'b0; m_cnt = 32'd0;
        end else begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("div_timeout", 32'(bus.div_timeout), 32'(m_to));
            check("stall_cnt", bus.stall_cnt, m_cnt);
            exp_stall = 6'h00;
            case (ev)
                0: begin
                    if (bus.stallreq_for_ex) begin
                        exp_stall = c_S_DIV; ev = 2; age = 1; mask = 0;
                    end else if (bus.stallreq_for_load && mask == 0) begin
                        exp_stall = c_S_LOAD;
                        if (c_LB == 1) mask = 1;
                        else begin ev = 1; age = 1; mask = 0; end
                    end else begin
                        if (bus.stallreq_for_bru) exp_stall = c_S_BRU;
                        mask = 0;
                    end
                end
                1: begin
                    exp_stall = c_S_LOAD;
                    if (age + 1 == c_LB) begin ev = 0; mask = 1; end
                    else age++;
                end
                default: begin
                    if (bus.div_ready) ev = 0;
                    else if (age == c_DIV) begin ev = 0; m_to = 1'b1; end
                    else begin exp_stall = c_S_DIV; age++; end
                end
            endcase
            check("stall", 32'(bus.stall), 32'(exp_stall));
            if (rec) seq_q.push_back(bus.stall);
            if (exp_stall != 6'h00 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            m_busy = (ev != 0);
        end
    end

    task automatic cyc(input logic ld, input logic bru, input logic ex, input logic rdy);
        @(posedge clk); #1;
        bus.stallreq_for_load = ld;
        bus.stallreq_for_bru  = bru;
        bus.stallreq_for_ex   = ex;
        bus.div_ready         = rdy;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.stallreq_for_load = 1'b0; bus.stallreq_for_bru = 1'b0;
        bus.stallreq_for_ex   = 1'b0; bus.div_ready        = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_seq(input string name, input int exp[$]);
        check({name, "_len"}, 32'(seq_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < seq_q.size(); i++)
            check(name, 32'(seq_q[i]), 32'(exp[i]));
    endtask

    initial begin
        int e[$];
        bus.stallreq_for_load = 1'b0; bus.stallreq_for_bru = 1'b0;
        bus.stallreq_for_ex   = 1'b0; bus.div_ready        = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        repeat (10) cyc(0, 0, 0, 0);
        #1;
        check("idle_stall_cnt", bus.stall_cnt, 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Load-use held for five cycles
        seq_q.delete();
        cyc(1, 0, 0, 0); rec = 1'b1;
        repeat (4) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0); rec = 1'b0;
        #1;
        check("load_stall_cnt", bus.stall_cnt, 32'd4);
        e = {7, 7, 0, 7, 7};
        check_seq("load_seq", e);
        repeat (3) cyc(0, 0, 0, 0);

        // Divide answered in the 5th DIV cycle
        do_reset();
        seq_q.delete();
        cyc(0, 0, 1, 0); rec = 1'b1;
        repeat (4) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0); rec = 1'b0;
        #1;
        check("div_stall_cnt", bus.stall_cnt, 32'd5);
        check("div_timeout_clear", 32'(bus.div_timeout), 32'd0);
        check("div_busy_after", 32'(bus.busy), 32'd0);
        e = {15, 15, 15, 15, 15, 0};
        check_seq("div_seq", e);

        // Divide that never answers
        do_reset();
        cyc(0, 0, 1, 0);
        repeat (32) cyc(0, 0, 0, 0);
        #1;
        check("to_last_stall", 32'(bus.stall), 32'h0F);
        cyc(0, 0, 0, 0);
        #1;
        check("to_release_stall", 32'(bus.stall), 32'd0);
        check("to_not_yet", 32'(bus.div_timeout), 32'd0);
        cyc(0, 0, 0, 0);
        #1;
        check("to_set", 32'(bus.div_timeout), 32'd1);
        check("to_stall_cnt", bus.stall_cnt, 32'd33);
        repeat (5) cyc(0, 0, 0, 0);
        #1;
        check("to_sticky", 32'(bus.div_timeout), 32'd1);

        // All three requests together, load/bru held through the divide
        do_reset();
        seq_q.delete();
        cyc(1, 1, 1, 0); rec = 1'b1;
        #1;
        check("all_req_stall", 32'(bus.stall), 32'h0F);
        repeat (3) cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0); rec = 1'b0;
        e = {15, 15, 15, 15, 0, 7};
        check_seq("all_req_seq", e);
        repeat (3) cyc(0, 0, 0, 0);

        // Reset in the 3rd DIV cycle, then a branch stall
        do_reset();
        cyc(0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_stall", 32'(bus.stall), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_stall_cnt", bus.stall_cnt, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seq_q.delete();
        cyc(0, 1, 0, 0); rec = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0); rec = 1'b0;
        #1;
        e = {3, 0};
        check_seq("bru_seq", e);
        check("bru_stall_cnt", bus.stall_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
